// File: rtl/sha3_pad_buffer.sv
// SHA3-256 absorb buffer: packs 64-bit lanes into 1088-bit rate blocks and
// applies pad10*1 (domain byte 0x06) to the final block of each message.
module sha3_pad_buffer #(
    parameter int unsigned LANE_W     = 64,
    parameter int unsigned RATE_LANES = 17
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [LANE_W-1:0]            in_data,
    input  logic                         in_last,
    input  logic [3:0]                   in_bytes,
    output logic                         in_ready,
    input  logic                         blk_ack,
    output logic [LANE_W*RATE_LANES-1:0] block_out,
    output logic                         buff_full,
    output logic                         first_blk,
    output logic                         last_blk
);

    localparam int unsigned BLK_W      = LANE_W * RATE_LANES;
    localparam int unsigned CNT_W      = $clog2(RATE_LANES);
    localparam int unsigned LANE_BYTES = LANE_W / 8;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATE_LANES - 1);
    localparam logic [3:0]       FULL_NB   = 4'(LANE_BYTES);

    typedef enum logic [1:0] {FILL, FULL, PAD} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               pad_pend;
    logic               accept;
    logic [3:0]         nb;
    logic               no_pad_fits;
    logic [LANE_W-1:0]  last_word;
    logic [BLK_W-1:0]   padded;
    logic [BLK_W-1:0]   pad_only;
    int unsigned        lane_idx;

    assign accept      = in_valid && in_ready;
    assign nb          = (in_bytes > FULL_NB) ? FULL_NB : in_bytes;
    assign no_pad_fits = (nb == FULL_NB) && (cnt == LAST_LANE);
    assign lane_idx    = 32'(cnt);

    // Final word: keep nb data bytes, drop 0x06 right after them if room remains
    always_comb begin
        last_word = '0;
        for (int unsigned k = 0; k < LANE_BYTES; k++) begin
            if (4'(k) < nb) begin
                last_word[8*k +: 8] = in_data[8*k +: 8];
            end else if (4'(k) == nb) begin
                last_word[8*k +: 8] = 8'h06;
            end
        end
    end

    always_comb begin
        padded = block_out;
        for (int unsigned i = 0; i < RATE_LANES; i++) begin
            if (i > lane_idx) begin
                padded[LANE_W*i +: LANE_W] = '0;
            end
        end
        padded[LANE_W*lane_idx +: LANE_W] = last_word;
        if ((nb == FULL_NB) && (cnt != LAST_LANE)) begin
            padded[LANE_W*(lane_idx+1) +: LANE_W] = LANE_W'(8'h06);
        end
        if (!no_pad_fits) begin
            padded[BLK_W-1 -: 8] = padded[BLK_W-1 -: 8] | 8'h80;
        end
    end

    always_comb begin
        pad_only             = '0;
        pad_only[7:0]        = 8'h06;
        pad_only[BLK_W-1 -: 8] = 8'h80;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (accept && (in_last || (cnt == LAST_LANE))) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (blk_ack) begin
                    state_nxt = (!last_blk && pad_pend) ? PAD : FILL;
                end
            end
            PAD:     state_nxt = FULL;
            default: state_nxt = FILL;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = (state == FILL) && !rst;
        buff_full = (state == FULL);
    end

    // Block datapath and message status
    always_ff @(posedge clk) begin
        if (rst) begin
            block_out <= '0;
            cnt       <= '0;
            pad_pend  <= 1'b0;
            last_blk  <= 1'b0;
            first_blk <= 1'b1;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        if (!in_last) begin
                            block_out[LANE_W*lane_idx +: LANE_W] <= in_data;
                            if (cnt == LAST_LANE) begin
                                cnt      <= '0;
                                last_blk <= 1'b0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else begin
                            block_out <= padded;
                            cnt       <= '0;
                            last_blk  <= !no_pad_fits;
                            pad_pend  <= no_pad_fits;
                        end
                    end
                end
                FULL: begin
                    if (blk_ack) begin
                        first_blk <= last_blk;
                        if (last_blk || !pad_pend) begin
                            block_out <= '0;
                            last_blk  <= 1'b0;
                        end
                    end
                end
                PAD: begin
                    block_out <= pad_only;
                    last_blk  <= 1'b1;
                    pad_pend  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_pad_buffer.sv
// Scoreboard bench for sha3_pad_buffer: stimulus queues expected blocks,
// a monitor checks each block when buff_full rises.
module tb_sha3_pad_buffer;

    localparam int unsigned BLK_W = 1088;
    localparam logic [63:0] TAIL  = 64'h8000_0000_0000_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [63:0]      in_data;
    logic             in_last;
    logic [3:0]       in_bytes;
    logic             in_ready;
    logic             blk_ack;
    logic [BLK_W-1:0] block_out;
    logic             buff_full;
    logic             first_blk;
    logic             last_blk;

    typedef struct {
        logic [BLK_W-1:0] blk;
        logic             first;
        logic             last;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_full = 1'b0;

    sha3_pad_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .in_ready  (in_ready),
        .blk_ack   (blk_ack),
        .block_out (block_out),
        .buff_full (buff_full),
        .first_blk (first_blk),
        .last_blk  (last_blk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic chk_blk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            for (int i = 0; i < 17; i++) begin
                if (act[64*i +: 64] !== req[64*i +: 64]) begin
                    $display("FAIL %s: lane %0d got %h, expected %h",
                             name, i, act[64*i +: 64], req[64*i +: 64]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [BLK_W-1:0] set_lane(input logic [BLK_W-1:0] b, input int i,
                                                   input logic [63:0] v);
        b[64*i +: 64] = v;
        return b;
    endfunction

    function automatic logic [63:0] word(input logic [63:0] base, input int i);
        return base | 64'(i);
    endfunction

    task automatic push_exp(input logic [BLK_W-1:0] b, input logic f, input logic l);
        exp_t e;
        e.blk   = b;
        e.first = f;
        e.last  = l;
        sb.push_back(e);
    endtask

    // Monitor: compare the presented block whenever buff_full rises
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (buff_full && !prev_full) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_block: got buff_full=1, expected no block");
                end else begin
                    e = sb.pop_front();
                    chk_blk("block_out", block_out, e.blk);
                    chk("first_blk", 64'(first_blk), 64'(e.first));
                    chk("last_blk", 64'(last_blk), 64'(e.last));
                end
            end
            prev_full = buff_full;
        end
    end

    task automatic send(input logic [63:0] d, input logic l, input logic [3:0] b);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_bytes = b;
        chk("in_ready_fill", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_words(input logic [63:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            send(word(base, i), 1'b0, 4'd0);
        end
    endtask

    task automatic ack_blk();
        int n = 0;
        while (!buff_full && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_full", 64'(buff_full), 64'd1);
        blk_ack = 1'b1;
        @(posedge clk);
        #1;
        blk_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BLK_W-1:0] b;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_bytes = 4'd0;
        blk_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("ready_in_reset", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_buff_full", 64'(buff_full), 64'd0);
        chk("rst_first_blk", 64'(first_blk), 64'd1);
        chk("rst_last_blk", 64'(last_blk), 64'd0);
        chk_blk("rst_block_out", block_out, '0);

        // Empty message
        b = set_lane(set_lane('0, 0, 64'h06), 16, TAIL);
        push_exp(b, 1'b1, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
        chk("latency_empty", 64'(buff_full), 64'd1);
        ack_blk();
        chk("ack_to_ready", 64'(in_ready), 64'd1);
        chk("first_after_last", 64'(first_blk), 64'd1);
        chk_blk("cleared_after_ack", block_out, '0);

        // "abc"
        b = set_lane(set_lane('0, 0, 64'h0000_0000_0663_6261), 16, TAIL);
        push_exp(b, 1'b1, 1'b1);
        send(64'h0000_0000_0063_6261, 1'b1, 4'd3);
        ack_blk();
        chk("abc_ready", 64'(in_ready), 64'd1);
        chk("abc_first", 64'(first_blk), 64'd1);

        // 17 full words then a 2-byte tail
        b = '0;
        for (int i = 0; i < 17; i++) b = set_lane(b, i, word(64'hA5A5_0000_0000_0000, i));
        push_exp(b, 1'b1, 1'b0);
        send_words(64'hA5A5_0000_0000_0000, 17);
        chk("latency_17", 64'(buff_full), 64'd1);
        ack_blk();
        chk("first_cleared", 64'(first_blk), 64'd0);
        b = set_lane(set_lane('0, 0, 64'h0000_0000_0006_BEEF), 16, TAIL);
        push_exp(b, 1'b0, 1'b1);
        send(64'hFFFF_FFFF_FFFF_BEEF, 1'b1, 4'd2);
        ack_blk();
        chk("first_set_again", 64'(first_blk), 64'd1);

        // Exactly 136 bytes: data block, gap, pad-only block
        b = '0;
        for (int i = 0; i < 17; i++) b = set_lane(b, i, word(64'h5A5A_0000_0000_0000, i));
        push_exp(b, 1'b1, 1'b0);
        push_exp(set_lane(set_lane('0, 0, 64'h06), 16, TAIL), 1'b0, 1'b1);
        send_words(64'h5A5A_0000_0000_0000, 16);
        send(word(64'h5A5A_0000_0000_0000, 16), 1'b1, 4'd8);
        ack_blk();
        chk("pad_gap_full", 64'(buff_full), 64'd0);
        chk("pad_gap_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("pad_full", 64'(buff_full), 64'd1);
        ack_blk();

        // Tail with 7 bytes in lane 16: byte 135 becomes 0x86
        b = '0;
        for (int i = 0; i < 16; i++) b = set_lane(b, i, word(64'h3C3C_0000_0000_0000, i));
        b = set_lane(b, 16, 64'h8611_2233_4455_6677);
        push_exp(b, 1'b1, 1'b1);
        send_words(64'h3C3C_0000_0000_0000, 16);
        send(64'hFF11_2233_4455_6677, 1'b1, 4'd7);
        ack_blk();

        // Full last word at lane 0 (in_bytes 12 acts as 8): 0x06 spills into lane 1
        b = set_lane(set_lane(set_lane('0, 0, 64'h0123_4567_89AB_CDEF), 1, 64'h06), 16, TAIL);
        push_exp(b, 1'b1, 1'b1);
        send(64'h0123_4567_89AB_CDEF, 1'b1, 4'd12);
        ack_blk();

        // in_valid held during FULL must not disturb the block
        b = '0;
        for (int i = 0; i < 17; i++) b = set_lane(b, i, word(64'h7E7E_0000_0000_0000, i));
        push_exp(b, 1'b1, 1'b0);
        send_words(64'h7E7E_0000_0000_0000, 17);
        in_valid = 1'b1;
        in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        in_last  = 1'b1;
        in_bytes = 4'd4;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("ready_low_full", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        ack_blk();

        // Reset in the middle of filling
        send_words(64'hC3C3_0000_0000_0000, 9);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", 64'(in_ready), 64'd0);
        chk("midrst_full", 64'(buff_full), 64'd0);
        chk("midrst_first", 64'(first_blk), 64'd1);
        chk("midrst_last", 64'(last_blk), 64'd0);
        chk_blk("midrst_block", block_out, '0);
        rst = 1'b0;
        #1;
        chk("postrst_ready", 64'(in_ready), 64'd1);
        push_exp(set_lane(set_lane('0, 0, 64'h06), 16, TAIL), 1'b1, 1'b1);
        send(64'h0, 1'b1, 4'd0);
        ack_blk();

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
